// File: rtl/pong_pkg.sv
// Shared Pong constants: VGA 640x480@60 timing, screen/object geometry and colours.
// Imported by the renderer and the game logic so both agree on the playfield.
package pong_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_ACTIVE     = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int SCREEN_WIDTH  = H_ACTIVE;
    localparam int SCREEN_HEIGHT = V_ACTIVE;
    localparam int BALL_SIZE     = 10;
    localparam int PADDLE_WIDTH  = 10;
    localparam int PADDLE_HEIGHT = 60;
    localparam int PADDLE_X      = 0;

    // Centred ball and paddle until the game logic supplies a first snapshot.
    localparam logic [9:0] BALL_X_RESET   = 10'd315;
    localparam logic [9:0] BALL_Y_RESET   = 10'd235;
    localparam logic [9:0] PADDLE_Y_RESET = 10'd210;

    localparam logic [5:0] COLOR_BALL   = 6'b111111;
    localparam logic [5:0] COLOR_PADDLE = 6'b001111;
    localparam logic [5:0] COLOR_NET    = 6'b010101;
    localparam logic [5:0] COLOR_BG     = 6'b000000;

    typedef struct packed {
        logic [9:0] ball_x;
        logic [9:0] ball_y;
        logic [9:0] paddle_y;
    } pos_t;

    typedef struct packed {
        logic       frame_tick;
        logic       hsync;
        logic       vsync;
        logic       de;
        logic [5:0] rgb;
    } vga_out_t;

    // 11-bit span test so lo+len can never wrap back onto the screen.
    function automatic logic in_span(input logic [10:0] p,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (p >= lo) && (p < lo + len);
    endfunction

endpackage

// File: rtl/pong_vga_timing.sv
// Free-running VGA raster counters with combinational sync/enable decodes.
// The renderer registers these decodes so they stay aligned with rgb.
module vga_timing
    import pong_pkg::*;
#(
    parameter int H_ACTIVE = pong_pkg::H_ACTIVE,
    parameter int H_FP     = pong_pkg::H_FP,
    parameter int H_SYNC   = pong_pkg::H_SYNC,
    parameter int H_BP     = pong_pkg::H_BP,
    parameter int V_ACTIVE = pong_pkg::V_ACTIVE,
    parameter int V_FP     = pong_pkg::V_FP,
    parameter int V_SYNC   = pong_pkg::V_SYNC,
    parameter int V_BP     = pong_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       de_raw,
    output logic       vblank_start
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign hsync_raw    = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
    assign vsync_raw    = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
    assign de_raw       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign vblank_start = (h_cnt == 10'd0) && (v_cnt == V_VIS);

endmodule

// File: rtl/pong_vga_renderer.sv
// Pong display path: snapshots game positions at vblank start and draws
// ball, paddle and net over VGA timing, with every output registered once.
module pong_vga_renderer
    import pong_pkg::*;
#(
    parameter int H_ACTIVE      = pong_pkg::H_ACTIVE,
    parameter int H_FP          = pong_pkg::H_FP,
    parameter int H_SYNC        = pong_pkg::H_SYNC,
    parameter int H_BP          = pong_pkg::H_BP,
    parameter int V_ACTIVE      = pong_pkg::V_ACTIVE,
    parameter int V_FP          = pong_pkg::V_FP,
    parameter int V_SYNC        = pong_pkg::V_SYNC,
    parameter int V_BP          = pong_pkg::V_BP,
    parameter int BALL_SIZE     = pong_pkg::BALL_SIZE,
    parameter int PADDLE_WIDTH  = pong_pkg::PADDLE_WIDTH,
    parameter int PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT,
    parameter int PADDLE_X      = pong_pkg::PADDLE_X
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_y,
    input  logic       pos_valid,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [5:0] rgb
);

    // Four-pixel-wide net straddling the horizontal centre.
    localparam logic [9:0] NET_LO = 10'(H_ACTIVE / 2 - 2);
    localparam logic [9:0] NET_HI = 10'(H_ACTIVE / 2 + 1);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        de_raw;
    logic        vblank_start;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        ball_hit;
    logic        paddle_hit;
    logic        net_hit;
    logic [5:0]  pixel;
    pos_t        shadow;
    vga_out_t    out_q;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .hsync_raw    (hsync_raw),
        .vsync_raw    (vsync_raw),
        .de_raw       (de_raw),
        .vblank_start (vblank_start)
    );

    // Positions change only at vblank start, so a displayed frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= pos_t'{BALL_X_RESET, BALL_Y_RESET, PADDLE_Y_RESET};
        end else if (vblank_start && pos_valid) begin
            shadow <= pos_t'{ball_x, ball_y, paddle_y};
        end
    end

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    assign ball_hit   = in_span(h_ext, {1'b0, shadow.ball_x}, 11'(BALL_SIZE))
                     && in_span(v_ext, {1'b0, shadow.ball_y}, 11'(BALL_SIZE));
    assign paddle_hit = in_span(h_ext, 11'(PADDLE_X), 11'(PADDLE_WIDTH))
                     && in_span(v_ext, {1'b0, shadow.paddle_y}, 11'(PADDLE_HEIGHT));
    assign net_hit    = (h_cnt >= NET_LO) && (h_cnt <= NET_HI) && !v_cnt[4];

    always_comb begin
        pixel = COLOR_BG;
        if (!de_raw) begin
            pixel = COLOR_BG;
        end else if (ball_hit) begin
            pixel = COLOR_BALL;
        end else if (paddle_hit) begin
            pixel = COLOR_PADDLE;
        end else if (net_hit) begin
            pixel = COLOR_NET;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= vga_out_t'{frame_tick: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                de: 1'b0, rgb: COLOR_BG};
        end else begin
            out_q <= vga_out_t'{frame_tick: vblank_start, hsync: hsync_raw,
                                vsync: vsync_raw, de: de_raw, rgb: pixel};
        end
    end

    assign frame_tick = out_q.frame_tick;
    assign hsync      = out_q.hsync;
    assign vsync      = out_q.vsync;
    assign de         = out_q.de;
    assign rgb        = out_q.rgb;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench for pong_vga_renderer: a reduced-raster instance for whole-frame behaviour
// plus a full 640x480 instance for the real timing constants over the first lines.
module tb_pong_vga_renderer;
    import pong_pkg::*;

    // Reduced raster: 80 x 55 clocks per frame, small objects, net at columns 30..33.
    localparam int S_HA = 64, S_HFP = 4, S_HS = 8, S_HBP = 4;
    localparam int S_VA = 48, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int S_BS = 4, S_PW = 3, S_PH = 12, S_PX = 2;
    localparam int F_HT = 800, F_FRAME = 420000;
    localparam logic [9:0] RST_OUT = 10'b0_1_1_0_000000;

    logic       clk = 1'b0;
    logic       rst_s = 1'b1;
    logic       rst_f = 1'b1;
    logic [9:0] ball_x = '0;
    logic [9:0] ball_y = '0;
    logic [9:0] paddle_y = '0;
    logic       pos_valid = 1'b0;
    logic       tick_s, hs_s, vs_s, de_s;
    logic [5:0] rgb_s;
    logic       tick_f, hs_f, vs_f, de_f;
    logic [5:0] rgb_f;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_s_q[$];
    logic [9:0] exp_f_q[$];
    int pos_s, pos_f;
    int sbx_s, sby_s, spy_s, sbx_f, sby_f, spy_f;
    int out_h_s = -1, out_v_s = -1, out_h_f = -1, out_v_f = -1;

    always #5 clk = ~clk;

    pong_vga_renderer #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .BALL_SIZE(S_BS), .PADDLE_WIDTH(S_PW), .PADDLE_HEIGHT(S_PH), .PADDLE_X(S_PX)
    ) dut_s (
        .clk(clk), .rst(rst_s), .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
        .pos_valid(pos_valid), .frame_tick(tick_s), .hsync(hs_s), .vsync(vs_s),
        .de(de_s), .rgb(rgb_s)
    );

    pong_vga_renderer dut_f (
        .clk(clk), .rst(rst_f), .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
        .pos_valid(pos_valid), .frame_tick(tick_f), .hsync(hs_f), .vsync(vs_f),
        .de(de_f), .rgb(rgb_f)
    );

    // Pixel (h,v) from the raster rules: {frame_tick, hsync, vsync, de, rgb}.
    function automatic logic [9:0] model(int h, int v, int bx, int by, int py,
                                         int ha, int hfp, int hs, int va, int vfp, int vs,
                                         int bs, int pw, int ph, int px);
        logic t, hn, vn, d;
        logic [5:0] c;
        d  = (h < ha) && (v < va);
        hn = !((h >= ha + hfp) && (h < ha + hfp + hs));
        vn = !((v >= va + vfp) && (v < va + vfp + vs));
        t  = (h == 0) && (v == va);
        c  = COLOR_BG;
        if (d) begin
            if (h >= bx && h < bx + bs && v >= by && v < by + bs) c = COLOR_BALL;
            else if (h >= px && h < px + pw && v >= py && v < py + ph) c = COLOR_PADDLE;
            else if (h >= ha / 2 - 2 && h <= ha / 2 + 1 && ((v / 16) % 2) == 0) c = COLOR_NET;
        end
        return {t, hn, vn, d, c};
    endfunction

    // Reference: raster position = clocks since reset, modulo the frame length.
    always @(posedge clk) begin
        int h, v;
        if (rst_s) begin
            pos_s = 0; sbx_s = 315; sby_s = 235; spy_s = 210;
            out_h_s = -1; out_v_s = -1;
            exp_s_q.push_back(RST_OUT);
        end else begin
            h = pos_s % S_HT; v = pos_s / S_HT;
            exp_s_q.push_back(model(h, v, sbx_s, sby_s, spy_s, S_HA, S_HFP, S_HS,
                                    S_VA, S_VFP, S_VS, S_BS, S_PW, S_PH, S_PX));
            out_h_s = h; out_v_s = v;
            if (h == 0 && v == S_VA && pos_valid) begin
                sbx_s = int'(ball_x); sby_s = int'(ball_y); spy_s = int'(paddle_y);
            end
            pos_s = (pos_s + 1) % S_FRAME;
        end
        if (rst_f) begin
            pos_f = 0; sbx_f = 315; sby_f = 235; spy_f = 210;
            out_h_f = -1; out_v_f = -1;
            exp_f_q.push_back(RST_OUT);
        end else begin
            h = pos_f % F_HT; v = pos_f / F_HT;
            exp_f_q.push_back(model(h, v, sbx_f, sby_f, spy_f, 640, 16, 96, 480, 10, 2,
                                    10, 10, 60, 0));
            out_h_f = h; out_v_f = v;
            if (h == 0 && v == 480 && pos_valid) begin
                sbx_f = int'(ball_x); sby_f = int'(ball_y); spy_f = int'(paddle_y);
            end
            pos_f = (pos_f + 1) % F_FRAME;
        end
    end

    // Scoreboard: every cycle, both instances against the reference.
    always @(negedge clk) begin
        logic [9:0] e;
        if (exp_s_q.size() > 0) begin
            e = exp_s_q.pop_front();
            vectors++;
            if ({tick_s, hs_s, vs_s, de_s, rgb_s} !== e) begin
                miscompares++;
                $display("FAIL small_out h=%0d v=%0d got=%b expected=%b", out_h_s, out_v_s,
                         {tick_s, hs_s, vs_s, de_s, rgb_s}, e);
            end
        end
        if (exp_f_q.size() > 0) begin
            e = exp_f_q.pop_front();
            vectors++;
            if ({tick_f, hs_f, vs_f, de_f, rgb_f} !== e) begin
                miscompares++;
                $display("FAIL full_out h=%0d v=%0d got=%b expected=%b", out_h_f, out_v_f,
                         {tick_f, hs_f, vs_f, de_f, rgb_f}, e);
            end
        end
    end

    task automatic check_val(input string name, input int got, input int expv);
        vectors++;
        if (got != expv) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic wait_px(input int h, input int v);
        bit found = 0;
        for (int i = 0; i < S_FRAME + 10 && !found; i++) begin
            @(negedge clk);
            if (out_h_s == h && out_v_s == v) found = 1;
        end
        if (!found) begin
            miscompares++;
            $display("FAIL wait_px(%0d,%0d) got=timeout expected=reached", h, v);
        end
    endtask

    task automatic check_px(input int h, input int v, input logic [5:0] expv);
        wait_px(h, v);
        vectors++;
        if (rgb_s !== expv) begin
            miscompares++;
            $display("FAIL pixel(%0d,%0d) got=%b expected=%b", h, v, rgb_s, expv);
        end
    endtask

    task automatic wait_tick();
        bit found = 0;
        for (int i = 0; i < S_FRAME + 10 && !found; i++) begin
            @(negedge clk);
            if (tick_s) found = 1;
        end
        if (!found) begin
            miscompares++;
            $display("FAIL wait_tick got=timeout expected=frame_tick");
        end
    endtask

    task automatic set_pos(input int bx, input int by, input int py, input logic pv);
        ball_x = 10'(bx); ball_y = 10'(by); paddle_y = 10'(py); pos_valid = pv;
    endtask

    initial begin
        int hs_lo, vs_lo, de_hi, ticks, f_hs_lo, f_de_hi;
        repeat (3) @(negedge clk);
        check_val("reset_out_small", int'({tick_s, hs_s, vs_s, de_s, rgb_s}), int'(RST_OUT));
        check_val("reset_out_full", int'({tick_f, hs_f, vs_f, de_f, rgb_f}), int'(RST_OUT));
        set_pos(10, 30, 20, 1'b1);
        rst_s = 1'b0; rst_f = 1'b0;

        // One full small frame and the first full-size line, counted from (0,0).
        hs_lo = 0; vs_lo = 0; de_hi = 0; ticks = 0; f_hs_lo = 0; f_de_hi = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            @(negedge clk);
            hs_lo += int'(!hs_s); vs_lo += int'(!vs_s); de_hi += int'(de_s); ticks += int'(tick_s);
            if (i < 800) begin
                f_hs_lo += int'(!hs_f); f_de_hi += int'(de_f);
            end
        end
        check_val("small_hsync_low_per_frame", hs_lo, 8 * 55);
        check_val("small_vsync_low_per_frame", vs_lo, 2 * 80);
        check_val("small_de_per_frame", de_hi, 64 * 48);
        check_val("small_ticks_per_frame", ticks, 1);
        check_val("full_hsync_low_per_line", f_hs_lo, 96);
        check_val("full_de_per_line", f_de_hi, 640);

        // Frame rendered from the first snapshot: ball (10,30), paddle rows 20..31.
        check_px(31, 0, COLOR_NET);
        check_px(31, 16, COLOR_BG);
        check_px(2, 20, COLOR_PADDLE);
        check_px(9, 30, COLOR_BG);
        check_px(10, 30, COLOR_BALL);
        check_px(14, 30, COLOR_BG);
        check_px(4, 31, COLOR_PADDLE);
        check_px(31, 32, COLOR_NET);
        check_px(13, 33, COLOR_BALL);

        // Mid-frame input change is invisible until the next tick.
        wait_px(0, 5);
        set_pos(40, 30, 20, 1'b1);
        check_px(10, 30, COLOR_BALL);
        check_px(40, 30, COLOR_BG);
        wait_tick();
        check_px(10, 30, COLOR_BG);
        check_px(40, 30, COLOR_BALL);

        // pos_valid low at the tick keeps the old shadows.
        set_pos(50, 10, 0, 1'b0);
        wait_tick();
        check_px(50, 10, COLOR_BG);
        check_px(2, 20, COLOR_PADDLE);
        check_px(40, 30, COLOR_BALL);

        // Ball over paddle wins.
        set_pos(3, 22, 20, 1'b1);
        wait_tick();
        check_px(2, 22, COLOR_PADDLE);
        check_px(3, 22, COLOR_BALL);
        check_px(6, 25, COLOR_BALL);
        check_px(7, 25, COLOR_BG);
        check_px(4, 26, COLOR_PADDLE);

        // Ball at the right edge is clipped, nothing wraps to column 0.
        set_pos(62, 40, 0, 1'b1);
        wait_tick();
        check_px(61, 40, COLOR_BG);
        check_px(62, 40, COLOR_BALL);
        check_px(63, 40, COLOR_BALL);
        check_px(0, 41, COLOR_BG);
        check_px(63, 43, COLOR_BALL);

        // Mid-frame reset: back to (0,0), no tick until line 48.
        wait_px(32, 24);
        rst_s = 1'b1;
        @(negedge clk);
        check_val("midframe_reset_out", int'({tick_s, hs_s, vs_s, de_s, rgb_s}), int'(RST_OUT));
        rst_s = 1'b0;
        ticks = 0;
        for (int i = 0; i < S_VA * S_HT; i++) begin
            @(negedge clk);
            ticks += int'(tick_s);
        end
        check_val("no_tick_before_vblank", ticks, 0);
        @(negedge clk);
        check_val("tick_at_vblank", int'(tick_s), 1);

        // Random positions and pos_valid every cycle, whole frames checked by the scoreboard.
        for (int i = 0; i < 4 * S_FRAME; i++) begin
            @(negedge clk);
            set_pos(int'($urandom_range(0, 70)), int'($urandom_range(0, 55)),
                    int'($urandom_range(0, 50)), 1'($urandom_range(0, 3) != 0));
        end
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
